// File: rtl/pkt_link_qfifo.sv
// Per-link packet buffer: one FIFO per qos class, strict-priority output
// arbitration with an age-based starvation guard and hold-while-stalled.
module pkt_link_qfifo #(
    parameter int unsigned QOS_W      = 1,
    parameter int unsigned ID_W       = 6,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8,
    localparam int unsigned NUM_CLS   = 2 ** QOS_W,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [QOS_W-1:0]        in_qos,
    input  logic [1:0]              in_type,
    input  logic [ID_W-1:0]         in_src,
    input  logic [ID_W-1:0]         in_tgt,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [QOS_W-1:0]        out_qos,
    output logic [1:0]              out_type,
    output logic [ID_W-1:0]         out_src,
    output logic [ID_W-1:0]         out_tgt,
    output logic [DATA_W-1:0]       out_data,
    output logic [NUM_CLS*CW-1:0]   occ,
    output logic                    starve_evt
);

    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PKT_W = QOS_W + 2 + 2 * ID_W + DATA_W;

    logic [PKT_W-1:0] r_mem    [NUM_CLS][DEPTH];
    logic [PW-1:0]    r_wr_ptr [NUM_CLS];
    logic [PW-1:0]    r_rd_ptr [NUM_CLS];
    logic [CW-1:0]    r_occ    [NUM_CLS];
    logic [7:0]       r_age    [NUM_CLS];
    logic             r_hold;
    logic             r_sel_st;
    logic [QOS_W-1:0] r_sel_q;
    logic             r_starve_evt;

    logic [NUM_CLS-1:0] w_ne;
    logic [NUM_CLS-1:0] w_st;
    logic [NUM_CLS-1:0] w_push_c;
    logic [NUM_CLS-1:0] w_pop_c;
    logic               w_any;
    logic               w_any_st;
    logic [QOS_W-1:0]   w_hi;
    logic [QOS_W-1:0]   w_hi_st;
    logic [QOS_W-1:0]   w_sel;
    logic               w_sel_st;
    logic               w_push;
    logic               w_pop;
    logic [PKT_W-1:0]   w_head;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Candidate scan: highest nonempty class and highest starving class
    always_comb begin
        w_ne     = '0;
        w_st     = '0;
        w_any    = 1'b0;
        w_any_st = 1'b0;
        w_hi     = '0;
        w_hi_st  = '0;
        for (int c = 0; c < int'(NUM_CLS); c++) begin
            w_ne[c] = (r_occ[c] != '0);
            w_st[c] = w_ne[c] && (r_age[c] >= 8'(STARVE_MAX));
            if (w_ne[c]) begin
                w_any = 1'b1;
                w_hi  = QOS_W'(c);
            end
            if (w_st[c]) begin
                w_any_st = 1'b1;
                w_hi_st  = QOS_W'(c);
            end
        end
    end

    assign w_sel    = r_hold ? r_sel_q : (w_any_st ? w_hi_st : w_hi);
    assign w_sel_st = r_hold ? r_sel_st : w_any_st;
    assign out_vld  = w_any;
    assign in_rdy   = (r_occ[in_qos] != CW'(DEPTH));
    assign w_push   = in_vld & in_rdy;
    assign w_pop    = w_any & out_rdy;

    always_comb begin
        w_push_c = '0;
        w_pop_c  = '0;
        for (int c = 0; c < int'(NUM_CLS); c++) begin
            w_push_c[c] = w_push && (in_qos == QOS_W'(c));
            w_pop_c[c]  = w_pop && (w_sel == QOS_W'(c));
        end
    end

    assign w_head = r_mem[w_sel][r_rd_ptr[w_sel]];
    assign {out_qos, out_type, out_src, out_tgt, out_data} = out_vld ? w_head : '0;

    // Payload storage carries no reset; visibility is governed by occupancy
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[in_qos][r_wr_ptr[in_qos]] <= {in_qos, in_type, in_src, in_tgt, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(NUM_CLS); c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_occ[c]    <= '0;
                r_age[c]    <= '0;
            end
            r_hold       <= 1'b0;
            r_sel_st     <= 1'b0;
            r_sel_q      <= '0;
            r_starve_evt <= 1'b0;
        end else begin
            for (int c = 0; c < int'(NUM_CLS); c++) begin
                if (w_push_c[c]) r_wr_ptr[c] <= nxt_ptr(r_wr_ptr[c]);
                if (w_pop_c[c])  r_rd_ptr[c] <= nxt_ptr(r_rd_ptr[c]);
                r_occ[c] <= r_occ[c] + CW'(w_push_c[c]) - CW'(w_pop_c[c]);
                // Age counts transfers won by a higher class while this one waits
                if (c == int'(NUM_CLS) - 1) begin
                    r_age[c] <= '0;
                end else if (w_pop) begin
                    if (w_pop_c[c] || !w_ne[c]) begin
                        r_age[c] <= '0;
                    end else if ((int'(w_sel) > c) && (r_age[c] != 8'hFF)) begin
                        r_age[c] <= r_age[c] + 8'd1;
                    end
                end
            end
            if (w_any && !out_rdy) begin
                r_hold   <= 1'b1;
                r_sel_q  <= w_sel;
                r_sel_st <= w_sel_st;
            end else begin
                r_hold   <= 1'b0;
            end
            r_starve_evt <= w_pop && w_sel_st;
        end
    end

    for (genvar g = 0; g < int'(NUM_CLS); g++) begin : g_occ
        assign occ[g*CW +: CW] = r_occ[g];
    end

    assign starve_evt = r_starve_evt;

endmodule
